// File: rtl/multmod_seq_if.sv
// Purpose: bundles the multiply-sequencer control and code signals.
//   master modport: the side that issues start/kill/microcode and observes
//                   the multfunc stream (testbench or upstream control).
//   slave modport:  the sequencer itself.
// Handshake: a start is taken on any rising clk edge where start=1,
//   ready=1 and kill=0; there is no separate acknowledge, the sequence
//   simply begins (nx_cyc0_rdy rises the following cycle). done is a
//   one-cycle pulse and needs no acknowledge.
// Signals: start, op_dp, op_spadd, kill, ucode_valid, ucode_multfunc (in to
//   sequencer); nx_multfunc_rom0, nx_multfunc_rom1, romsel, nx_cyc0_rdy,
//   ready, busy, done, dbg_state (out of sequencer; dbg_state is the FSM
//   state encoding 0=IDLE 1=CYC0 2=RUN 3=DONE).
interface multmod_seq_if #(
  parameter int CODE_W = 4
);
  logic              start;
  logic              op_dp;
  logic              op_spadd;
  logic              kill;
  logic              ucode_valid;
  logic [CODE_W-1:0] ucode_multfunc;
  logic [CODE_W-1:0] nx_multfunc_rom0;
  logic [CODE_W-1:0] nx_multfunc_rom1;
  logic [1:0]        romsel;
  logic              nx_cyc0_rdy;
  logic              ready;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  modport master (
    output start, op_dp, op_spadd, kill, ucode_valid, ucode_multfunc,
    input  nx_multfunc_rom0, nx_multfunc_rom1, romsel, nx_cyc0_rdy,
           ready, busy, done, dbg_state
  );

  modport slave (
    input  start, op_dp, op_spadd, kill, ucode_valid, ucode_multfunc,
    output nx_multfunc_rom0, nx_multfunc_rom1, romsel, nx_cyc0_rdy,
           ready, busy, done, dbg_state
  );
endinterface

// File: rtl/multmod_seq.sv
// Purpose: multiply-cycle sequencer feeding the multiplier decode/mux stage.
//   On an accepted start it issues one accumulator-clear cycle (CYC0), then
//   one multfunc code per cycle (SP: 1,2 ; DP: 4..d), then a one-cycle done
//   pulse. In IDLE a microcode multfunc can be passed through on rom1.
// Ports: clk, reset (synchronous, active-high), bus (multmod_seq_if.slave).
// Configuration: define MULTMOD_SEQ_SPADD_EN to append code e (SP_ADD) to
//   the SP sequence when op_spadd was set with start; undefined, op_spadd
//   is ignored and code e is never produced.
// All outputs come straight from flops.
module multmod_seq #(
  parameter int         CODE_W   = 4,
  parameter logic [1:0] ZERO_SEL = 2'h2
) (
  input logic         clk,
  input logic         reset,
  multmod_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CYC0 = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic              dp_q, dp_d;
  logic              spadd_q, spadd_d;
  logic [3:0]        last_step;
  logic              ucode_take;
  logic              take_start;

  logic [CODE_W-1:0] rom0_q, rom0_d;
  logic [CODE_W-1:0] rom1_q, rom1_d;
  logic [1:0]        romsel_q, romsel_d;
  logic              cyc0_q, busy_q, done_q, ready_q;

  // Code for a given step of the sequence; DP codes run 4..d contiguously.
  function automatic logic [CODE_W-1:0] seq_code(input logic dp, input logic [3:0] step);
    if (dp) return CODE_W'(4'h4 + step);
    case (step)
      4'd0:    return CODE_W'(4'h1);
      4'd1:    return CODE_W'(4'h2);
      default: return CODE_W'(4'he);
    endcase
  endfunction

  // The sequence end is decoded from the step count, never from a wrap.
  assign last_step = dp_q ? 4'd9 : (spadd_q ? 4'd2 : 4'd1);

`ifdef MULTMOD_SEQ_SPADD_EN
  logic spadd_in;
  assign spadd_in = bus.op_spadd;
`else
  logic spadd_in;
  logic spadd_unused;
  assign spadd_in     = 1'b0;
  assign spadd_unused = bus.op_spadd;
`endif

  // kill always suppresses a same-cycle start.
  assign take_start = bus.start && !bus.kill;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dp_d       = dp_q;
    spadd_d    = spadd_q;
    ucode_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_start) begin
          state_d = CYC0;
          step_d  = 4'd0;
          dp_d    = bus.op_dp;
          spadd_d = spadd_in;
        end else if (bus.ucode_valid && !bus.start) begin
          ucode_take = 1'b1;
        end
      end
      CYC0: begin
        state_d = bus.kill ? IDLE : RUN;
        step_d  = 4'd0;
      end
      RUN: begin
        if (bus.kill || step_q > last_step) begin
          state_d = IDLE;
        end else if (step_q == last_step) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (take_start) begin
          state_d = CYC0;
          step_d  = 4'd0;
          dp_d    = bus.op_dp;
          spadd_d = spadd_in;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output values for the cycle after this edge, decoded from state_d.
    rom0_d   = '0;
    rom1_d   = '0;
    romsel_d = ZERO_SEL;
    if (state_d == RUN) rom0_d = seq_code(dp_d, step_d);
    if (state_d == CYC0 || state_d == RUN) begin
      romsel_d = 2'h0;
    end else if (ucode_take) begin
      rom1_d   = bus.ucode_multfunc;
      romsel_d = 2'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= 4'd0;
      dp_q     <= 1'b0;
      spadd_q  <= 1'b0;
      rom0_q   <= '0;
      rom1_q   <= '0;
      romsel_q <= ZERO_SEL;
      cyc0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dp_q     <= dp_d;
      spadd_q  <= spadd_d;
      rom0_q   <= rom0_d;
      rom1_q   <= rom1_d;
      romsel_q <= romsel_d;
      cyc0_q   <= (state_d == CYC0);
      busy_q   <= (state_d == CYC0) || (state_d == RUN);
      done_q   <= (state_d == DONE);
      ready_q  <= (state_d == IDLE) || (state_d == DONE);
    end
  end

  assign bus.nx_multfunc_rom0 = rom0_q;
  assign bus.nx_multfunc_rom1 = rom1_q;
  assign bus.romsel           = romsel_q;
  assign bus.nx_cyc0_rdy      = cyc0_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.ready            = ready_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_multmod_seq.sv
// Purpose: self-checking bench for multmod_seq. Inputs are driven and
//   outputs sampled on the falling clock edge; the DUT acts on the rising
//   edge. A monitor pops expected multfunc codes from exp_q whenever the
//   DUT is issuing codes.
module tb_multmod_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [3:0] exp_q[$];

  multmod_seq_if #(.CODE_W(4)) bus ();

  multmod_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MULTMOD_SEQ_SPADD_EN
  localparam bit SPADD_ON = 1'b1;
`else
  localparam bit SPADD_ON = 1'b0;
`endif

  typedef struct {
    logic dp;
    logic spadd;
    int   lat;
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_codes(input logic dp, input logic spadd);
    if (dp) begin
      for (int i = 0; i < 10; i++) exp_q.push_back(4'(4 + i));
    end else begin
      exp_q.push_back(4'h1);
      exp_q.push_back(4'h2);
      if (spadd && SPADD_ON) exp_q.push_back(4'he);
    end
  endtask

  // Code monitor: every RUN cycle must present the next expected code.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.dbg_state == 2'd2) begin
      if (exp_q.size() == 0) begin
        check("unexpected_code", bus.nx_multfunc_rom0, 8'hff);
      end else begin
        check("rom0_code", bus.nx_multfunc_rom0, exp_q.pop_front());
        check("run_romsel", bus.romsel, 8'h0);
      end
    end
  end

  // Issues a start in the current (falling-edge) cycle and waits for done.
  // Returns on the done cycle, so a following call is back-to-back.
  task automatic run_op(input logic dp, input logic spadd, input int lat, input logic with_ucode);
    int got;
    push_codes(dp, spadd);
    bus.start    = 1'b1;
    bus.op_dp    = dp;
    bus.op_spadd = spadd;
    if (with_ucode) begin
      bus.ucode_valid    = 1'b1;
      bus.ucode_multfunc = 4'hc;
    end
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start       = 1'b0;
        bus.ucode_valid = 1'b0;
        check("cyc0_rdy", bus.nx_cyc0_rdy, 8'h1);
        check("cyc0_romsel", bus.romsel, 8'h0);
        check("cyc0_rom0", bus.nx_multfunc_rom0, 8'h0);
        check("cyc0_rom1", bus.nx_multfunc_rom1, 8'h0);
        check("cyc0_busy", bus.busy, 8'h1);
      end
      if (bus.done === 1'b1) begin
        got = k;
        break;
      end
    end
    check("done_latency", 8'(got), 8'(lat));
    check("done_romsel", bus.romsel, 8'h2);
    check("done_rom0", bus.nx_multfunc_rom0, 8'h0);
    check("done_ready", bus.ready, 8'h1);
    check("codes_drained", 8'(exp_q.size()), 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   got_done;
    vecs[0] = '{dp: 1'b0, spadd: 1'b0, lat: 4};
    vecs[1] = '{dp: 1'b1, spadd: 1'b0, lat: 12};
    vecs[2] = '{dp: 1'b0, spadd: 1'b1, lat: SPADD_ON ? 5 : 4};
    vecs[3] = '{dp: 1'b1, spadd: 1'b1, lat: 12};
    vecs[4] = '{dp: 1'b0, spadd: 1'(SPADD_ON), lat: SPADD_ON ? 5 : 4};

    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.op_dp          = 1'b0;
    bus.op_spadd       = 1'b0;
    bus.kill           = 1'b0;
    bus.ucode_valid    = 1'b0;
    bus.ucode_multfunc = 4'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_romsel", bus.romsel, 8'h2);
    check("rst_rom0", bus.nx_multfunc_rom0, 8'h0);
    check("rst_rom1", bus.nx_multfunc_rom1, 8'h0);
    check("rst_ready", bus.ready, 8'h1);
    check("rst_done", bus.done, 8'h0);
    check("rst_busy", bus.busy, 8'h0);
    check("rst_cyc0", bus.nx_cyc0_rdy, 8'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_romsel", bus.romsel, 8'h2);

    // Table of sequences, run back-to-back (each start lands on the prior done).
    for (int i = 0; i < 5; i++) run_op(vecs[i].dp, vecs[i].spadd, vecs[i].lat, 1'b0);
    @(negedge clk);
    check("post_idle_state", bus.dbg_state, 8'h0);
    check("post_idle_done", bus.done, 8'h0);
    check("post_idle_romsel", bus.romsel, 8'h2);

    // Microcode pass-through in IDLE, then cleared.
    bus.ucode_valid    = 1'b1;
    bus.ucode_multfunc = 4'hc;
    @(negedge clk);
    bus.ucode_valid = 1'b0;
    check("ucode_rom1", bus.nx_multfunc_rom1, 8'hc);
    check("ucode_romsel", bus.romsel, 8'h1);
    @(negedge clk);
    check("ucode_clr_rom1", bus.nx_multfunc_rom1, 8'h0);
    check("ucode_clr_romsel", bus.romsel, 8'h2);

    // start and ucode together: start wins.
    run_op(1'b0, 1'b0, 4, 1'b1);
    @(negedge clk);

    // kill beats start in IDLE.
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    check("killstart_cyc0", bus.nx_cyc0_rdy, 8'h0);
    check("killstart_state", bus.dbg_state, 8'h0);
    check("killstart_ready", bus.ready, 8'h1);

    // DP killed at code 7; ucode held high during the run must be ignored.
    push_codes(1'b1, 1'b0);
    bus.start = 1'b1;
    bus.op_dp = 1'b1;
    @(negedge clk);
    bus.start          = 1'b0;
    bus.ucode_valid    = 1'b1;
    bus.ucode_multfunc = 4'h9;
    got_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.nx_multfunc_rom0 == 4'h7) break;
      @(negedge clk);
    end
    check("kill_at_code7", bus.nx_multfunc_rom0, 8'h7);
    check("run_ucode_ignored", bus.nx_multfunc_rom1, 8'h0);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill        = 1'b0;
    bus.ucode_valid = 1'b0;
    exp_q.delete();
    check("kill_romsel", bus.romsel, 8'h2);
    check("kill_rom0", bus.nx_multfunc_rom0, 8'h0);
    check("kill_state", bus.dbg_state, 8'h0);
    check("kill_busy", bus.busy, 8'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got_done++;
    end
    check("kill_no_done", 8'(got_done), 8'h0);

    // Reset in the middle of a DP sequence.
    push_codes(1'b1, 1'b0);
    bus.start = 1'b1;
    bus.op_dp = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_romsel", bus.romsel, 8'h2);
    check("midrst_rom0", bus.nx_multfunc_rom0, 8'h0);
    check("midrst_ready", bus.ready, 8'h1);
    check("midrst_busy", bus.busy, 8'h0);
    got_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got_done++;
    end
    check("midrst_no_done", 8'(got_done), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
